// File: rtl/act_pkg.sv
// Shared types and helpers for the sigmoid activation arbiter.
package act_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned ID_W    = 3;

    localparam logic [15:0] Q8_8_ONE  = 16'h0100;
    localparam logic [15:0] Q8_8_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_e;

    // First valid index searched from ptr upward, wrapping modulo n.
    function automatic logic [ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    ptr,
                                                 input int unsigned         n);
        logic [ID_W-1:0] pick;
        logic            found;
        int unsigned     j;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            j = (32'(ptr) + i) % n;
            if (!found && (i < n) && valid[j[ID_W-1:0]]) begin
                pick  = ID_W'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over N_REQ requesters; the last winner becomes lowest priority.
module rr_arbiter
    import act_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] valid,
    output logic [N_REQ-1:0] grant_c,
    output logic [ID_W-1:0]  idx_c,
    output logic             accept_c
);

    logic [ID_W-1:0]    ptr_q;
    logic [MAX_REQ-1:0] valid_ext;

    assign valid_ext = MAX_REQ'(valid);
    assign idx_c     = rr_pick(valid_ext, ptr_q, N_REQ);
    assign accept_c  = en && (|valid);
    assign grant_c   = accept_c ? (N_REQ'(1) << idx_c) : '0;

    // Pointer moves just past the accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept_c) begin
            ptr_q <= (idx_c == ID_W'(N_REQ - 1)) ? '0 : idx_c + ID_W'(1);
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one combinational Q8.8 sigmoid unit among N_REQ requesters, with
// saturation bypass for |x| >= SAT_TH and a registered valid/ready response.
module sigmoid_arbiter
    import act_pkg::*;
#(
    parameter int unsigned    N_REQ  = 4,
    parameter int unsigned    DW     = 16,
    parameter logic [DW-1:0]  SAT_TH = DW'(16'h0400)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       act_x,
    input  logic [DW-1:0]       act_y,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DW-1:0]       rsp_y,
    input  logic                rsp_ready
);

    state_e          state_q, state_d;
    logic [DW-1:0]   x_q, x_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            rsp_valid_d;
    logic [ID_W-1:0] rsp_id_d;
    logic [DW-1:0]   rsp_y_d;

    logic            grant_en_c;
    logic            accept_c;
    logic [ID_W-1:0] idx_c;
    logic [DW-1:0]   x_sel_c;
    logic            sat_hi_c, sat_lo_c;

    // Grants only in IDLE or while the current response is being consumed.
    assign grant_en_c = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (grant_en_c),
        .valid    (req_valid),
        .grant_c  (req_ready),
        .idx_c    (idx_c),
        .accept_c (accept_c)
    );

    assign x_sel_c  = req_x[32'(idx_c)*DW +: DW];
    assign sat_hi_c = $signed(x_q) >= $signed(SAT_TH);
    assign sat_lo_c = $signed(x_q) <= -$signed(SAT_TH);
    assign act_x    = x_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_y_d     = rsp_y;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    x_d     = x_sel_c;
                    id_d    = idx_c;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                if (sat_hi_c)      rsp_y_d = DW'(Q8_8_ONE);
                else if (sat_lo_c) rsp_y_d = DW'(Q8_8_ZERO);
                else               rsp_y_d = act_y;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (accept_c) begin
                        x_d     = x_sel_c;
                        id_d    = idx_c;
                        state_d = EVAL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            id_q      <= id_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_y     <= rsp_y_d;
        end
    end

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Scoreboard bench for sigmoid_arbiter with a stand-in sigmoid unit.
module tb_sigmoid_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_x;
    logic [N_REQ-1:0]    req_ready;
    logic [DW-1:0]       act_x;
    logic [DW-1:0]       act_y;
    logic                rsp_valid;
    logic [2:0]          rsp_id;
    logic [DW-1:0]       rsp_y;
    logic                rsp_ready;

    always #5 clk = ~clk;

    sigmoid_arbiter #(.N_REQ(N_REQ), .DW(DW), .SAT_TH(16'h0400)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .act_x     (act_x),
        .act_y     (act_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_ready (rsp_ready)
    );

    // Stand-in unit: linear, deliberately off-range for large |x|.
    function automatic logic [15:0] model_sig(input logic [15:0] x);
        return 16'h0080 + 16'($signed(x) >>> 2);
    endfunction

    function automatic logic [15:0] exp_y(input logic [15:0] x);
        if ($signed(x) >= $signed(16'h0400))      return 16'h0100;
        else if ($signed(x) <= $signed(16'hFC00)) return 16'h0000;
        else                                       return model_sig(x);
    endfunction

    assign act_y = model_sig(act_x);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  id;
        logic [15:0] y;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    logic prev_rv = 1'b0;
    logic seen_id2 = 1'b0;

    always @(posedge clk) cyc++;

    // Monitor: push on acceptance, check latency and pop on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            prev_rv = 1'b0;
        end else begin
            chk("gnt_onehot", 32'($onehot0(req_ready)), 32'd1);
            chk("gnt_valid", 32'(req_ready & ~req_valid), 32'd0);
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id  = 3'(i);
                    e.y   = exp_y(req_x[i*DW +: DW]);
                    e.cyc = cyc;
                    sbq.push_back(e);
                    if (i == 2) seen_id2 = 1'b1;
                end
            end
            if (rsp_valid && !prev_rv) begin
                if (sbq.size() == 0) chk("rsp_spurious", 32'd1, 32'd0);
                else                 chk("latency", 32'(cyc - sbq[0].cyc), 32'd2);
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_y", 32'(rsp_y), 32'(e.y));
                end
            end
            prev_rv = rsp_valid;
        end
    end

    // Serve pending requests with rsp_ready=1 until everything has drained.
    task automatic drain(input int max);
        int n;
        logic [N_REQ-1:0] acc;
        logic busy;
        n = 0;
        busy = 1'b1;
        rsp_ready = 1'b1;
        while (busy && n < max) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            n++;
            busy = (req_valid != '0) || (sbq.size() != 0) || rsp_valid;
        end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    task automatic single(input int idx, input logic [15:0] x);
        req_x[idx*DW +: DW] = x;
        req_valid = 4'(1 << idx);
        drain(20);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] sx[8];
        logic [15:0] y0;
        logic [2:0]  id0;
        int          n;
        int          prev_hs;

        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_act_x", 32'(act_x), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed values including both saturation boundaries.
        sx = '{16'h0000, 16'h0400, 16'hFC00, 16'h03FF, 16'hFC01, 16'h7FFF, 16'h8000, 16'h0100};
        for (int i = 0; i < 8; i++) single(0, sx[i]);
        for (int i = 0; i < 6; i++) single(int'($urandom_range(0, 3)), 16'($urandom));

        // Round-robin with all requesters held valid.
        pulse_reset();
        for (int i = 0; i < int'(N_REQ); i++) req_x[i*DW +: DW] = 16'(16'h0040 * (i + 1));
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        prev_hs = 0;
        for (int k = 0; k < 12; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(rsp_valid && rsp_ready) && n < 10);
            chk("rr_timeout", 32'(n >= 10), 32'd0);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            if (k > 0) chk("rr_gap", 32'(cyc - prev_hs), 32'd2);
            prev_hs = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        drain(20);

        // Backpressure with a withdrawn requester 2.
        pulse_reset();
        rsp_ready = 1'b0;
        seen_id2  = 1'b0;
        req_x[1*DW +: DW] = 16'h0100;
        req_x[2*DW +: DW] = 16'h0123;
        req_x[3*DW +: DW] = 16'h0200;
        req_x[0*DW +: DW] = 16'hFF00;
        req_valid = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[1] && n < 10);
        chk("bp_accept_timeout", 32'(n >= 10), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        chk("bp_rsp_timeout", 32'(n >= 10), 32'd0);
        y0  = rsp_y;
        id0 = rsp_id;
        chk("bp_first_y", 32'(y0), 32'h00C0);
        chk("bp_first_id", 32'(id0), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            req_valid = (c == 0) ? 4'b0100 : 4'b1001;
            @(negedge clk);
            chk("bp_y_stable", 32'(rsp_y), 32'(y0));
            chk("bp_id_stable", 32'(rsp_id), 32'(id0));
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            chk("bp_valid_held", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        #1;
        chk("bp_regrant", 32'(req_ready), 32'b1000);
        drain(40);
        chk("withdrawn_never_granted", 32'(seen_id2), 32'd0);

        // Reset asserted while in EVAL.
        req_x[2*DW +: DW] = 16'h0200;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[2] && n < 10);
        chk("mr_accept_timeout", 32'(n >= 10), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mr_act_x", 32'(act_x), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_rsp_id", 32'(rsp_id), 32'd0);
        chk("mr_rsp_y", 32'(rsp_y), 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mr_first_grant", 32'(req_ready), 32'b0001);
        drain(40);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
